// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the dot-product sequencer and the 32-bit
// multiply-accumulate register it drives.
//
// Contents:
//   OPERAND_W, ACC_W      operand and accumulator widths
//   MAC_OP_*              opcode values understood by the MAC register
//   state_t               sequencer FSM state encoding
//   operand_t             one buffered operand pair {last, a, b}
// -----------------------------------------------------------------------------
package mac_pkg;

   localparam int OPERAND_W = 16;
   localparam int ACC_W     = 32;

   // MAC register opcodes: hold keeps the register, load writes {a,b},
   // accumulate adds the unsigned product a*b (wrapping mod 2^32).
   localparam logic [1:0] MAC_OP_HOLD = 2'd0;
   localparam logic [1:0] MAC_OP_LOAD = 2'd1;
   localparam logic [1:0] MAC_OP_ACC  = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_ACCUM = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Field order fixes the 33-bit FIFO word layout: {last, a, b}.
   typedef struct packed {
      logic                 last;
      logic [OPERAND_W-1:0] a;
      logic [OPERAND_W-1:0] b;
   } operand_t;

endpackage

// File: rtl/MACRegister.sv
// -----------------------------------------------------------------------------
// MACRegister
// 32-bit multiply-accumulate register driven by the dot-product sequencer.
// It has no reset; the sequencer zeroes it with a load of {0,0} before each
// vector.
//
// Ports:
//   clk       clock
//   opcode    0 hold, 1 load {a,b}, 2 accumulate a*b (unsigned, wraps)
//   a, b      16-bit operands
//   dataOut   current register value
// -----------------------------------------------------------------------------
module MACRegister
   import mac_pkg::*;
(
   input  logic                 clk,
   input  logic [1:0]           opcode,
   input  logic [OPERAND_W-1:0] a,
   input  logic [OPERAND_W-1:0] b,
   output logic [ACC_W-1:0]     dataOut
);

   logic [ACC_W-1:0] product;

   assign product = ACC_W'(a) * ACC_W'(b);

   always_ff @(posedge clk) begin
      case (opcode)
         MAC_OP_LOAD: dataOut <= {a, b};
         MAC_OP_ACC:  dataOut <= dataOut + product;
         default:     dataOut <= dataOut;
      endcase
   end

endmodule

// File: rtl/operand_fifo.sv
// -----------------------------------------------------------------------------
// operand_fifo
// Synchronous FIFO buffering operand pairs for the dot-product sequencer.
// Registered storage with a combinational head: an entry pushed at a clock
// edge appears on rdata in the following cycle (no write-through bypass).
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (empties the FIFO)
//   push, wdata  write request and data; ignored while full, even if a pop
//                happens in the same cycle
//   pop, rdata   read request and current head; pop ignored while empty
//   count        number of stored entries (0..DEPTH)
//   full, empty  occupancy flags
// -----------------------------------------------------------------------------
module operand_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 33
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int COUNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == COUNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage needs no reset: an entry is only visible once count says so.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dot_product_sequencer.sv
// -----------------------------------------------------------------------------
// dot_product_sequencer
// Control stage in front of the 32-bit MAC register. Operand pairs are
// buffered in a small FIFO; for each vector the sequencer clears the MAC
// register, issues one accumulate per pair until the pair tagged last, then
// captures the MAC register output and offers it on a valid/ready port.
//
// Handshakes (both ports): a transfer happens in a cycle where valid and
// ready are both high at the rising clock edge. The producer holds its data
// stable while valid is high and ready is low; ready never depends on valid.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand input handshake (in_ready = FIFO not full)
//   in_a, in_b, in_last   operand pair and end-of-vector tag
//   mac_opcode/a/b        combinational drive of the MAC register inputs
//   mac_data              MAC register output
//   res_valid/res_ready   result handshake
//   res_data, res_terms   dot product and saturating count of pairs
//   busy                  FSM not idle or operands still queued
// -----------------------------------------------------------------------------
module dot_product_sequencer
   import mac_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [OPERAND_W-1:0] in_a,
   input  logic [OPERAND_W-1:0] in_b,
   input  logic                 in_last,
   output logic [1:0]           mac_opcode,
   output logic [OPERAND_W-1:0] mac_a,
   output logic [OPERAND_W-1:0] mac_b,
   input  logic [ACC_W-1:0]     mac_data,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [ACC_W-1:0]     res_data,
   output logic [CNT_W-1:0]     res_terms,
   output logic                 busy
);

   localparam int COUNT_W = $clog2(DEPTH) + 1;

   state_t             state;
   state_t             next_state;
   operand_t           push_entry;
   operand_t           head;
   logic               push;
   logic               pop;
   logic               full;
   logic               empty;
   logic [COUNT_W-1:0] fifo_count;
   logic [CNT_W-1:0]   term_cnt;
   logic               cnt_clear;
   logic               cnt_inc;
   logic               latch_res;
   logic               res_accept;

   // ---------------------------------------------------------------------
   // Operand buffer
   // ---------------------------------------------------------------------
   assign push_entry = {in_last, in_a, in_b};
   assign in_ready   = !full;
   assign push       = in_valid && in_ready;

   operand_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(operand_t))
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (push_entry),
      .pop   (pop),
      .rdata (head),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   assign busy = (state != ST_IDLE) || (fifo_count != '0);

   // ---------------------------------------------------------------------
   // FSM: next state and MAC drive
   // ---------------------------------------------------------------------
   always_comb begin
      next_state = state;
      mac_opcode = MAC_OP_HOLD;
      mac_a      = '0;
      mac_b      = '0;
      pop        = 1'b0;
      cnt_clear  = 1'b0;
      cnt_inc    = 1'b0;
      latch_res  = 1'b0;
      res_accept = 1'b0;

      case (state)
         ST_IDLE: begin
            if (!empty) begin
               next_state = ST_CLEAR;
            end
         end

         // Loading {0,0} zeroes the MAC register, which has no reset.
         ST_CLEAR: begin
            mac_opcode = MAC_OP_LOAD;
            cnt_clear  = 1'b1;
            next_state = ST_ACCUM;
         end

         // An empty FIFO here is a bubble: hold the MAC and wait.
         ST_ACCUM: begin
            if (!empty) begin
               pop        = 1'b1;
               mac_opcode = MAC_OP_ACC;
               mac_a      = head.a;
               mac_b      = head.b;
               cnt_inc    = 1'b1;
               if (head.last) begin
                  next_state = ST_DRAIN;
               end
            end
         end

         // The last accumulate landed at the end of the previous cycle, so
         // mac_data now carries the final sum.
         ST_DRAIN: begin
            latch_res  = 1'b1;
            next_state = ST_DONE;
         end

         // Pushes continue to land in the FIFO; nothing is popped until the
         // result has been taken.
         ST_DONE: begin
            if (res_valid && res_ready) begin
               res_accept = 1'b1;
               next_state = ST_IDLE;
            end
         end

         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State, term counter and result registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         term_cnt  <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_terms <= '0;
      end else begin
         state <= next_state;

         // Saturates so very long vectors report all-ones rather than wrap.
         if (cnt_clear) begin
            term_cnt <= '0;
         end else if (cnt_inc && (term_cnt != '1)) begin
            term_cnt <= term_cnt + 1'b1;
         end

         if (latch_res) begin
            res_data  <= mac_data;
            res_terms <= term_cnt;
            res_valid <= 1'b1;
         end else if (res_accept) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/dot_product_sequencer.md
Name: dot_product_sequencer

Overview:
Upstream control stage for the 32-bit multiply-accumulate register. It buffers a stream of 16-bit operand pairs and drives that register's opcode, a and b inputs, clearing it before each vector and issuing one MAC per pair. After the pair tagged last, it returns the accumulated 32-bit dot product on a valid/ready result port.

Parameters:
DEPTH, 4, operand FIFO entries (power of two, ≥2)
CNT_W, 8, width of term counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept (= !full)
in_a  in  16  operand a
in_b  in  16  operand b
in_last  in  1  final pair of vector
mac_opcode  out  2  to MAC register opcode (0 hold, 1 load {a,b}, 2 accumulate)
mac_a  out  16  to MAC register a
mac_b  out  16  to MAC register b
mac_data  in  32  MAC register dataOut
res_valid  out  1  result valid
res_ready  in  1  result accepted
res_data  out  32  dot product
res_terms  out  CNT_W  pairs accumulated
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (rst_n low at posedge) has the following effects:
  - state IDLE, FIFO empty, res_valid=0, res_data=0, res_terms=0, term counter=0.
  - Pushes are ignored while rst_n is low.
  - The MAC register itself is not reset; correctness relies on CLEAR.
- Reset mid-vector aborts the vector. Queued pairs are discarded and no result is produced.
- mac_* outputs are combinational from the state and the FIFO head. The MAC register captures them at the end of the same cycle.
- FIFO behaviour:
  - A push occurs on in_valid && in_ready. A pushed entry is visible at the head the next cycle; there is no bypass.
  - There is no push when full, even if a pop occurs the same cycle.
  - A simultaneous push and pop when not full is allowed, and the count is unchanged.
- IDLE: mac_opcode=0. If the FIFO is non-empty, go to CLEAR.
- CLEAR: mac_opcode=1, mac_a=0, mac_b=0, which zeroes the MAC register. Term counter := 0. Go to ACCUM. Nothing is popped.
- ACCUM behaviour:
  - If the FIFO is non-empty:
    - pop the head;
    - drive mac_opcode=2, mac_a=head.a, mac_b=head.b;
    - counter += 1, saturating at all-ones;
    - if head.last, go to DRAIN.
  - If the FIFO is empty: mac_opcode=0, mac_a=mac_b=0, stay in ACCUM (bubble).
- DRAIN: mac_opcode=0. mac_data now holds the final sum. Latch res_data:=mac_data and res_terms:=counter, set res_valid=1, go to DONE.
- DONE behaviour:
  - mac_opcode=0; res_data and res_terms are held stable.
  - The FIFO keeps accepting pushes but nothing is popped.
  - On res_valid && res_ready: res_valid:=0, go to IDLE.
- Latency: with N pairs present back-to-back, res_valid rises N+3 cycles after the first pair becomes visible (IDLE, CLEAR, N×ACCUM, DRAIN).
- Throughput: one vector per N+4 cycles minimum, counting the handshake cycle.
- Arithmetic is owned by the MAC register:
  - products are unsigned 16×16;
  - the sum wraps mod 2^32;
  - there is no overflow flag.
- Boundary rules:
  - A vector of one pair is legal.
  - A long vector saturates res_terms at 2^CNT_W-1 while still accumulating.
  - in_last on a pair pushed while in DONE applies to the next vector.

Decomposition:
- Package mac_pkg:
  - MAC_OP_HOLD=2'd0, MAC_OP_LOAD=2'd1, MAC_OP_ACC=2'd2;
  - state encoding IDLE/CLEAR/ACCUM/DRAIN/DONE;
  - OPERAND_W=16, ACC_W=32.
- Sub-module operand_fifo: synchronous FIFO, width 33 ({last,a,b}), DEPTH entries, with count, full and empty.
- FSM, counter and result registers stay in dot_product_sequencer.
- The bench instantiates the sequencer together with MACRegister.

Test Plan:
1. Single pair (3,4,last=1) → res_data=12, res_terms=1, res_valid 4 cycles after the pair becomes visible; mac_opcode sequence 0,1,2,0.
2. Pairs (1,2),(3,4),(5,6),(7,8,last) back-to-back → res_data=100, res_terms=4, res_valid at cycle 7.
3. Pairs (0xFFFF,0xFFFF)×2, last on the second → res_data=0xFFFC0002 (wrap), res_terms=2.
4. Hold res_ready=0 for 12 cycles while pushing a second vector (10,10,last) plus fillers → first result held stable, in_ready=0 at DEPTH entries. After the handshake the second result is 100 with no carry-over from the first.
5. Vector (2,2),(3,3,last) with 3 idle cycles between pairs → mac_opcode=0 during the gaps, res_data=13, res_terms=2.
6. Assert rst_n=0 for 1 cycle mid-ACCUM of a 4-pair vector → next cycle all outputs at reset values and busy=0. Then vector (2,3,last) → res_data=6, res_terms=1.
